ctrl_data_deskew: RTL and testbench

Output-side deskew and write-back controller for the systolic array. Result lanes leave the array bottom diagonally skewed, the inverse of the input-side diagonal setup. This block realigns each result row into a single word and writes the rows to the Unified Buffer at consecutive addresses. A start/busy/done handshake with the top-level sequencer brackets each transfer.

---
 rtl/ctrl_data_deskew.sv | 132 +++++++++++++
 tb/tb_ctrl_data_deskew.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_data_deskew.sv
// Output-side deskew and Unified Buffer write-back controller.
// Lane i of the skewed array output is delayed by i stages so that every lane of a row lines up.
// The aligned row is then registered once more and written to consecutive UB addresses.
// A start/busy/done handshake brackets each transfer.
module ctrl_data_deskew #(
  parameter int unsigned DATA_BW     = 8,
  parameter int unsigned MATRIX_SIZE = 8,
  parameter int unsigned ADDR_BW     = 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           start,
  input  logic [ADDR_BW-1:0]             base_addr,
  input  logic [ADDR_BW-1:0]             num_rows,
  input  logic                           in_valid,
  input  logic [DATA_BW*MATRIX_SIZE-1:0] data_in,
  output logic                           ub_wr_en,
  output logic [ADDR_BW-1:0]             ub_wr_addr,
  output logic [DATA_BW*MATRIX_SIZE-1:0] ub_wr_data,
  output logic                           busy,
  output logic                           done
);

  localparam int unsigned RowBw = DATA_BW * MATRIX_SIZE;

  typedef enum logic [1:0] {StIdle, StCollect, StDrain, StDone} state_e;

  state_e             state_q, state_d;
  logic [ADDR_BW-1:0] base_q, rows_q, acc_cnt_q, wr_cnt_q, wr_cnt_d;
  logic               start_ok, accept;
  logic [MATRIX_SIZE-2:0] vld_q;
  logic [RowBw-1:0]   aligned;

  // A start is honoured only when no transfer is in flight (IDLE or the DONE cycle).
  assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));
  assign accept   = in_valid && (state_q == StCollect);
  // Write count including the write presented this cycle, so DONE follows the last write directly.
  assign wr_cnt_d = wr_cnt_q + ADDR_BW'(ub_wr_en);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) state_d = (num_rows == '0) ? StDone : StCollect;
        else       state_d = StIdle;
      end
      StCollect: begin
        if (accept && ((acc_cnt_q + ADDR_BW'(1)) == rows_q)) state_d = StDrain;
      end
      StDrain: begin
        if (wr_cnt_d == rows_q) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    busy = (state_q == StCollect) || (state_q == StDrain);
    done = (state_q == StDone);
  end

  // Transfer parameters and row counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      base_q    <= '0;
      rows_q    <= '0;
      acc_cnt_q <= '0;
      wr_cnt_q  <= '0;
    end else if (start_ok) begin
      base_q    <= base_addr;
      rows_q    <= num_rows;
      acc_cnt_q <= '0;
      wr_cnt_q  <= '0;
    end else begin
      if (accept) acc_cnt_q <= acc_cnt_q + ADDR_BW'(1);
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign ub_wr_addr = base_q + wr_cnt_q;

  // Per-lane deskew delay lines: lane i carries i stages, lane 0 is a straight wire.
  for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
    if (i == 0) begin : g_wire
      assign aligned[0 +: DATA_BW] = data_in[0 +: DATA_BW];
    end else begin : g_dly
      logic [DATA_BW-1:0] stg_q [i];

      // Shift lane i through its i stages.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int unsigned j = 0; j < i; j++) stg_q[j] <= '0;
        end else begin
          stg_q[0] <= data_in[DATA_BW*i +: DATA_BW];
          for (int unsigned j = 1; j < i; j++) stg_q[j] <= stg_q[j-1];
        end
      end

      assign aligned[DATA_BW*i +: DATA_BW] = stg_q[i-1];
    end
  end

  // Accepted-row marker delayed to match the deepest lane.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= accept;
      for (int unsigned k = 1; k < MATRIX_SIZE - 1; k++) vld_q[k] <= vld_q[k-1];
    end
  end

  // Common output register for the write strobe and aligned row.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ub_wr_en   <= 1'b0;
      ub_wr_data <= '0;
    end else begin
      ub_wr_en   <= vld_q[MATRIX_SIZE-2];
      ub_wr_data <= aligned;
    end
  end

endmodule

// File: tb/tb_ctrl_data_deskew.sv
// Directed bench for ctrl_data_deskew (8 lanes x 8 bits, 8-bit addresses).
// Cycle c starts at a rising edge; inputs change 1 time unit after it, outputs are sampled on
// the following falling edge.
module tb_ctrl_data_deskew;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [7:0]  num_rows = '0;
  logic        in_valid = 1'b0;
  logic [63:0] data_in = '0;
  logic        ub_wr_en;
  logic [7:0]  ub_wr_addr;
  logic [63:0] ub_wr_data;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  ctrl_data_deskew #(
    .DATA_BW    (8),
    .MATRIX_SIZE(8),
    .ADDR_BW    (8)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .base_addr (base_addr),
    .num_rows  (num_rows),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .ub_wr_en  (ub_wr_en),
    .ub_wr_addr(ub_wr_addr),
    .ub_wr_data(ub_wr_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Skewed input for the basic test: lane i of row r (16r+i) appears at cycle 2+r+(7-i).
  function automatic logic [63:0] basic_lanes(input int c);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      int r;
      r = c - 9 + i;
      if (r >= 0 && r < 3) v[8*i +: 8] = 8'(16 * r + i);
    end
    return v;
  endfunction

  function automatic logic [63:0] basic_row(input int r);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = 8'(16 * r + i);
    return v;
  endfunction

  // With every lane driven to the cycle number, row accepted at t0 has lane i = t0+7-i.
  function automatic logic [63:0] ramp_row(input int t0);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = 8'(t0 + 7 - i);
    return v;
  endfunction

  initial begin
    logic       en_x;
    logic [7:0] addr_x;

    // Reset state
    #12;
    check("rst_en", 64'(ub_wr_en), 64'(0));
    check("rst_addr", 64'(ub_wr_addr), 64'(0));
    check("rst_data", ub_wr_data, 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    @(posedge clk); #1;
    rstn = 1'b1;

    // Basic transfer: 3 rows at base 0x10
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      start     = (c == 0);
      base_addr = 8'h10;
      num_rows  = 8'd3;
      in_valid  = (c >= 2 && c <= 4);
      data_in   = basic_lanes(c);
      @(negedge clk);
      en_x = (c >= 10 && c <= 12);
      check("basic_en", 64'(ub_wr_en), 64'(en_x));
      if (en_x) begin
        check("basic_addr", 64'(ub_wr_addr), 64'(8'h10 + c - 10));
        check("basic_data", ub_wr_data, basic_row(c - 10));
      end
      check("basic_done", 64'(done), 64'(c == 13));
      check("basic_busy", 64'(busy), 64'(c >= 1 && c <= 12));
    end

    // Zero rows
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      start     = (c == 0);
      base_addr = 8'h77;
      num_rows  = 8'd0;
      in_valid  = 1'b0;
      data_in   = '0;
      @(negedge clk);
      check("zero_en", 64'(ub_wr_en), 64'(0));
      check("zero_done", 64'(done), 64'(c == 1));
      check("zero_busy", 64'(busy), 64'(0));
    end

    // Pre-start valids and surplus valids
    for (int c = 0; c < 17; c++) begin
      @(posedge clk); #1;
      start     = (c == 2);
      base_addr = 8'h40;
      num_rows  = 8'd2;
      in_valid  = (c == 0 || c == 1 || (c >= 4 && c <= 8));
      data_in   = {8{8'(c)}};
      @(negedge clk);
      en_x = (c == 12 || c == 13);
      check("extra_en", 64'(ub_wr_en), 64'(en_x));
      if (en_x) begin
        check("extra_addr", 64'(ub_wr_addr), 64'(8'h40 + c - 12));
        check("extra_data", ub_wr_data, ramp_row(c - 8));
      end
      check("extra_done", 64'(done), 64'(c == 14));
      check("extra_busy", 64'(busy), 64'(c >= 3 && c <= 13));
    end

    // Address wrap, then start in the DONE cycle, then an ignored start while busy
    for (int c = 0; c < 27; c++) begin
      @(posedge clk); #1;
      start     = (c == 0 || c == 13 || c == 17);
      base_addr = (c < 13) ? 8'hFE : (c < 17) ? 8'h80 : 8'h20;
      num_rows  = (c < 13) ? 8'd4 : (c < 17) ? 8'd1 : 8'd5;
      in_valid  = (c >= 1 && c <= 4) || (c == 15);
      data_in   = {8{8'(c)}};
      @(negedge clk);
      en_x   = (c >= 9 && c <= 12) || (c == 23);
      addr_x = (c <= 12) ? 8'(8'hFE + c - 9) : 8'h80;
      check("wrap_en", 64'(ub_wr_en), 64'(en_x));
      if (en_x) begin
        check("wrap_addr", 64'(ub_wr_addr), 64'(addr_x));
        check("wrap_data", ub_wr_data, ramp_row(c - 8));
      end
      check("wrap_done", 64'(done), 64'(c == 13 || c == 24));
      check("wrap_busy", 64'(busy), 64'((c >= 1 && c <= 12) || (c >= 14 && c <= 23)));
    end

    // Mid-transfer reset after the first of 3 writes
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      start     = (c == 0);
      base_addr = 8'h30;
      num_rows  = 8'd3;
      in_valid  = (c >= 1 && c <= 3);
      data_in   = {8{8'(c)}};
      @(negedge clk);
      check("mrst_en", 64'(ub_wr_en), 64'(c == 9));
      if (c == 9) check("mrst_addr", 64'(ub_wr_addr), 64'(8'h30));
    end
    #2;
    rstn = 1'b0;
    #1;
    check("mrst_now_en", 64'(ub_wr_en), 64'(0));
    check("mrst_now_addr", 64'(ub_wr_addr), 64'(0));
    check("mrst_now_data", ub_wr_data, 64'(0));
    check("mrst_now_busy", 64'(busy), 64'(0));
    check("mrst_now_done", 64'(done), 64'(0));
    start    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      start    = 1'b0;
      in_valid = (c < 3);
      @(negedge clk);
      check("mrst_post_en", 64'(ub_wr_en), 64'(0));
      check("mrst_post_done", 64'(done), 64'(0));
      check("mrst_post_busy", 64'(busy), 64'(0));
    end
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      start     = (c == 0);
      base_addr = 8'h50;
      num_rows  = 8'd1;
      in_valid  = (c == 1);
      data_in   = {8{8'(c)}};
      @(negedge clk);
      check("again_en", 64'(ub_wr_en), 64'(c == 9));
      if (c == 9) begin
        check("again_addr", 64'(ub_wr_addr), 64'(8'h50));
        check("again_data", ub_wr_data, ramp_row(1));
      end
      check("again_done", 64'(done), 64'(c == 10));
      check("again_busy", 64'(busy), 64'(c >= 1 && c <= 9));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
